frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: clears the framebuffer to a background colour, then walks the
// VRAM triangle slots, handing each to the rasterizer and forwarding its pixel writes.
module frame_sequencer #(
  parameter int unsigned DISPLAY_WIDTH  = 320,
  parameter int unsigned DISPLAY_HEIGHT = 240,
  parameter int unsigned VRAM_SIZE      = 256,
  parameter int unsigned PIXEL_BITS     = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           frame_start,
  input  logic [PIXEL_BITS-1:0]                          bg_color,
  input  logic [$clog2(VRAM_SIZE):0]                     tri_count,
  output logic                                           busy,
  output logic                                           frame_done,
  output logic [$clog2(VRAM_SIZE)-1:0]                   vram_rd_addr,
  output logic                                           raster_req,
  input  logic                                           raster_ack,
  input  logic                                           rast_fb_wr_en,
  input  logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] rast_fb_wr_addr,
  input  logic [PIXEL_BITS-1:0]                          rast_fb_wr_data,
  output logic                                           fb_wr_en,
  output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] fb_wr_addr,
  output logic [PIXEL_BITS-1:0]                          fb_wr_data
);

  localparam int unsigned NumPix  = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int unsigned SlotW   = $clog2(VRAM_SIZE);
  localparam int unsigned CountW  = SlotW + 1;
  localparam int unsigned FbAddrW = $clog2(NumPix);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StRender,
    StDone
  } state_e;

  state_e                state_q;
  logic [PIXEL_BITS-1:0] bg_q;
  logic [CountW-1:0]     count_q;
  logic [FbAddrW-1:0]    clear_q;
  logic [SlotW-1:0]      slot_q;

  logic [CountW-1:0] count_clamped;
  logic              clear_last;
  logic              slot_last;
  logic              rast_in_range;

  assign count_clamped = (tri_count > CountW'(VRAM_SIZE)) ? CountW'(VRAM_SIZE) : tri_count;
  assign clear_last    = (clear_q == FbAddrW'(NumPix - 1));
  assign slot_last     = ({1'b0, slot_q} == (count_q - CountW'(1)));
  // One extra bit so the bound is representable even when NumPix is a power of two.
  assign rast_in_range = ({1'b0, rast_fb_wr_addr} < (FbAddrW + 1)'(NumPix));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      bg_q    <= '0;
      count_q <= '0;
      clear_q <= '0;
      slot_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            bg_q    <= bg_color;
            count_q <= count_clamped;
            clear_q <= '0;
            slot_q  <= '0;
            state_q <= StClear;
          end
        end
        StClear: begin
          // Hold at the last address rather than wrapping.
          if (clear_last) begin
            state_q <= (count_q == '0) ? StDone : StFetch;
          end else begin
            clear_q <= clear_q + FbAddrW'(1);
          end
        end
        StFetch: begin
          state_q <= StRender;
        end
        StRender: begin
          if (raster_ack) begin
            if (slot_last) begin
              state_q <= StDone;
            end else begin
              slot_q  <= slot_q + SlotW'(1);
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy         = (state_q != StIdle);
  assign frame_done   = (state_q == StDone);
  assign raster_req   = (state_q == StRender);
  assign vram_rd_addr = slot_q;

  always_comb begin
    fb_wr_en   = 1'b0;
    fb_wr_addr = '0;
    fb_wr_data = '0;
    case (state_q)
      StClear: begin
        fb_wr_en   = 1'b1;
        fb_wr_addr = clear_q;
        fb_wr_data = bg_q;
      end
      StRender: begin
        fb_wr_en   = rast_fb_wr_en && rast_in_range;
        fb_wr_addr = rast_fb_wr_addr;
        fb_wr_data = rast_fb_wr_data;
      end
      default: begin
      end
    endcase
  end

endmodule
